// File: rtl/cla_pkg.sv
// Shared types and carry-lookahead helpers for the pipelined 32-bit add/subtract unit.
package cla_pkg;

   localparam int WORD_W  = 32;
   localparam int GROUP_W = 4;
   localparam int HALF_W  = 16;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [HALF_W-1:0] half_t;

   typedef struct packed {
      logic p;
      logic g;
   } pg_t;

   // Group propagate/generate of a 4-bit slice.
   function automatic pg_t group_pg(input logic [3:0] p, input logic [3:0] g);
      pg_t r;
      r.p = &p;
      r.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      return r;
   endfunction

   // Flattened lookahead carries into positions 0..3 of a 4-wide slice.
   function automatic logic [3:0] carries4(input logic [2:0] p, input logic [2:0] g,
                                           input logic c0);
      logic [3:0] c;
      c[0] = c0;
      c[1] = g[0] | (p[0] & c0);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      return c;
   endfunction

endpackage

// File: rtl/cla_block16.sv
// Combinational 16-bit two-level carry-lookahead adder: four 4-bit groups under
// one second-level lookahead unit.
module cla_block16
   import cla_pkg::*;
(
   input  logic [HALF_W-1:0] a,
   input  logic [HALF_W-1:0] b,
   input  logic              cin,
   output logic [HALF_W-1:0] s,
   output logic              c_msb_in,
   output logic              cout
);

   localparam int NGRP = HALF_W / GROUP_W;

   half_t            p;
   half_t            g;
   half_t            c;
   logic [NGRP-1:0]  grp_p;
   logic [NGRP-1:0]  grp_g;
   logic [NGRP-1:0]  grp_c;
   pg_t              blk;

   assign p = a ^ b;
   assign g = a & b;

   always_comb begin
      grp_p = '0;
      grp_g = '0;
      c     = '0;
      for (int i = 0; i < NGRP; i++) begin
         {grp_p[i], grp_g[i]} = group_pg(p[GROUP_W*i +: GROUP_W], g[GROUP_W*i +: GROUP_W]);
      end
      // Second level resolves the carry into each group from group P/G only.
      grp_c = carries4(grp_p[NGRP-2:0], grp_g[NGRP-2:0], cin);
      blk   = group_pg(grp_p, grp_g);
      for (int i = 0; i < NGRP; i++) begin
         c[GROUP_W*i +: GROUP_W] = carries4(p[GROUP_W*i +: GROUP_W-1],
                                            g[GROUP_W*i +: GROUP_W-1], grp_c[i]);
      end
   end

   assign s        = p ^ c;
   assign c_msb_in = c[HALF_W-1];
   assign cout     = blk.g | (blk.p & cin);

endmodule

// File: rtl/cla_addsub_pipe32.sv
// Two-stage pipelined 32-bit add/subtract: low half resolved in stage 1, high half
// plus flags in stage 2, valid/ready handshake on both sides.
module cla_addsub_pipe32
   import cla_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   if (WIDTH != WORD_W || GROUP != GROUP_W) begin : g_bad_params
      $error("cla_addsub_pipe32 supports only WIDTH=32, GROUP=4");
   end

   word_t bi;
   logic  c0;
   logic  in_fire;
   logic  s2_adv;
   logic  s1_ready;
   half_t s_lo;
   half_t s_hi;
   logic  c16;
   logic  c15_unused;
   logic  c31;
   logic  c32;

   logic  vld_p1_d,    vld_p1_q;
   half_t sum_lo_p1_d, sum_lo_p1_q;
   half_t a_hi_p1_d,   a_hi_p1_q;
   half_t bi_hi_p1_d,  bi_hi_p1_q;
   logic  c16_p1_d,    c16_p1_q;

   logic  vld_p2_d,    vld_p2_q;
   word_t sum_p2_d,    sum_p2_q;
   logic  cout_p2_d,   cout_p2_q;
   logic  ovf_p2_d,    ovf_p2_q;
   logic  zero_p2_d,   zero_p2_q;

   assign bi = b ^ {WIDTH{sub}};
   assign c0 = sub | cin;

   // ---- stage 1: low half ----
   cla_block16 u_lo (
      .a        (a[HALF_W-1:0]),
      .b        (bi[HALF_W-1:0]),
      .cin      (c0),
      .s        (s_lo),
      .c_msb_in (c15_unused),
      .cout     (c16)
   );

   // ---- stage 2: high half, carry-in taken from the stage 1 register ----
   cla_block16 u_hi (
      .a        (a_hi_p1_q),
      .b        (bi_hi_p1_q),
      .cin      (c16_p1_q),
      .s        (s_hi),
      .c_msb_in (c31),
      .cout     (c32)
   );

   // The out_ready -> in_ready combinational path is intentional: full throughput
   // with a one-deep stage per half.
   always_comb begin
      s2_adv   = vld_p1_q & (~vld_p2_q | out_ready);
      s1_ready = ~vld_p1_q | s2_adv;
      in_fire  = in_valid & s1_ready;

      vld_p1_d    = in_fire ? 1'b1 : (s2_adv ? 1'b0 : vld_p1_q);
      sum_lo_p1_d = in_fire ? s_lo : sum_lo_p1_q;
      a_hi_p1_d   = in_fire ? a[WIDTH-1:HALF_W] : a_hi_p1_q;
      bi_hi_p1_d  = in_fire ? bi[WIDTH-1:HALF_W] : bi_hi_p1_q;
      c16_p1_d    = in_fire ? c16 : c16_p1_q;

      vld_p2_d  = s2_adv ? 1'b1 : ((vld_p2_q & out_ready) ? 1'b0 : vld_p2_q);
      sum_p2_d  = s2_adv ? {s_hi, sum_lo_p1_q} : sum_p2_q;
      cout_p2_d = s2_adv ? c32 : cout_p2_q;
      ovf_p2_d  = s2_adv ? (c31 ^ c32) : ovf_p2_q;
      zero_p2_d = s2_adv ? ~|{s_hi, sum_lo_p1_q} : zero_p2_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1_q  <= 1'b0;
         vld_p2_q  <= 1'b0;
         sum_p2_q  <= '0;
         cout_p2_q <= 1'b0;
         ovf_p2_q  <= 1'b0;
         zero_p2_q <= 1'b0;
      end else begin
         vld_p1_q  <= vld_p1_d;
         vld_p2_q  <= vld_p2_d;
         sum_p2_q  <= sum_p2_d;
         cout_p2_q <= cout_p2_d;
         ovf_p2_q  <= ovf_p2_d;
         zero_p2_q <= zero_p2_d;
      end
   end

   always_ff @(posedge clk) begin
      sum_lo_p1_q <= sum_lo_p1_d;
      a_hi_p1_q   <= a_hi_p1_d;
      bi_hi_p1_q  <= bi_hi_p1_d;
      c16_p1_q    <= c16_p1_d;
   end

   assign in_ready  = s1_ready;
   assign out_valid = vld_p2_q;
   assign sum       = sum_p2_q;
   assign cout      = cout_p2_q;
   assign ovf       = ovf_p2_q;
   assign zero      = zero_p2_q;

endmodule

// File: tb/tb_cla_addsub_pipe32.sv
// Bench for cla_addsub_pipe32: directed table, stream/stall/reset sequences and a
// randomized run, all scored against an arithmetic reference model.
`timescale 1ns/1ps
module tb_cla_addsub_pipe32;

   logic        clk, rst, in_valid, in_ready, sub, cin, out_valid, out_ready;
   logic        cout, ovf, zero;
   logic [31:0] a, b, sum;

   typedef struct packed {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
   } res_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic        cin;
      res_t        exp;
   } vec_t;

   res_t q[$];
   res_t e;
   int   n_vec = 0;
   int   n_bad = 0;
   int   n_out = 0;

   cla_addsub_pipe32 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer arithmetic, overflow judged on the true signed result.
   function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                  input logic s, input logic ci);
      longint unsigned ux, uy, ur;
      longint          sx, sy, sr;
      res_t            r;
      ux = {32'b0, x};
      uy = {32'b0, y};
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (s) begin
         ur     = ux - uy;
         sr     = sx - sy;
         r.cout = (ux >= uy);
      end else begin
         ur     = ux + uy + {63'b0, ci};
         sr     = sx + sy + longint'({63'b0, ci});
         r.cout = (ur >= 64'h1_0000_0000);
      end
      r.sum  = ur[31:0];
      r.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      r.zero = (r.sum == 32'h0);
      return r;
   endfunction

   function automatic vec_t mk(input logic [31:0] x, input logic [31:0] y, input logic s,
                               input logic ci, input logic [31:0] es, input logic ec,
                               input logic ev, input logic ez);
      vec_t v;
      v.a = x; v.b = y; v.sub = s; v.cin = ci;
      v.exp.sum = es; v.exp.cout = ec; v.exp.ovf = ev; v.exp.zero = ez;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_res(input string name, input res_t r);
      check({name, "_sum"},  sum,  r.sum);
      check({name, "_cout"}, {31'b0, cout}, {31'b0, r.cout});
      check({name, "_ovf"},  {31'b0, ovf},  {31'b0, r.ovf});
      check({name, "_zero"}, {31'b0, zero}, {31'b0, r.zero});
   endtask

   task automatic rand_op();
      logic [31:0] pick [6];
      pick[0] = $urandom; pick[1] = 32'h0; pick[2] = 32'hFFFF_FFFF;
      pick[3] = 32'h7FFF_FFFF; pick[4] = 32'h8000_0000; pick[5] = 32'h0000_FFFF;
      a   = pick[$urandom_range(0, 5)];
      b   = ($urandom_range(0, 1) == 0) ? $urandom : pick[$urandom_range(0, 5)];
      sub = $urandom_range(0, 1);
      cin = $urandom_range(0, 1);
   endtask

   // Scoreboard: handshake signals are stable at the falling edge, so what is seen
   // here is what the following rising edge will transfer.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
      end else begin
         if (out_valid && out_ready) begin
            n_out++;
            if (q.size() == 0) begin
               check("spurious_out", {31'b0, out_valid}, 32'h0);
            end else begin
               e = q.pop_front();
               check_res("sb", e);
            end
         end
         if (in_valid && in_ready) q.push_back(model(a, b, sub, cin));
      end
   end

   initial begin
      vec_t        tbl [7];
      logic [31:0] snap_sum;
      logic        snap_c, snap_v, snap_z, fire;
      int          acc, n0;
      res_t        r;

      tbl[0] = mk(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
      tbl[1] = mk(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      tbl[2] = mk(32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      tbl[3] = mk(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      tbl[4] = mk(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      tbl[5] = mk(32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b0);
      tbl[6] = mk(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; sub = 1'b0; cin = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("rst_out_valid", {31'b0, out_valid}, 32'h0);
      check("rst_in_ready",  {31'b0, in_ready},  32'h1);
      check_res("rst", '0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Directed table, one operation at a time, with latency checks.
      foreach (tbl[i]) begin
         @(posedge clk); #1;
         a = tbl[i].a; b = tbl[i].b; sub = tbl[i].sub; cin = tbl[i].cin;
         in_valid = 1'b1; out_ready = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         check($sformatf("tbl%0d_lat1", i), {31'b0, out_valid}, 32'h0);
         @(posedge clk); #1;
         check($sformatf("tbl%0d_valid", i), {31'b0, out_valid}, 32'h1);
         check_res($sformatf("tbl%0d", i), tbl[i].exp);
      end

      // Back-to-back stream of 8 operations.
      for (int c = 0; c <= 10; c++) begin
         @(posedge clk); #1;
         out_ready = 1'b1;
         if (c < 8) begin
            rand_op();
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (c < 8) check($sformatf("stream_in_ready%0d", c), {31'b0, in_ready}, 32'h1);
         check($sformatf("stream_out_valid%0d", c), {31'b0, out_valid},
               {31'b0, (c >= 2 && c <= 9)});
      end

      // Stall: consumer blocked, producer always offering.
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; rand_op();
      acc = 0;
      for (int c = 0; c < 7; c++) begin
         #1 fire = in_ready;
         @(posedge clk); #1;
         if (fire) begin
            acc++;
            rand_op();
         end
      end
      check("stall_accepts", acc, 2);
      check("stall_in_ready", {31'b0, in_ready}, 32'h0);
      check("stall_out_valid", {31'b0, out_valid}, 32'h1);
      snap_sum = sum; snap_c = cout; snap_v = ovf; snap_z = zero;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check("stall_hold_in_ready", {31'b0, in_ready}, 32'h0);
         check("stall_hold_valid", {31'b0, out_valid}, 32'h1);
         check("stall_hold_sum", sum, snap_sum);
         check("stall_hold_flags", {29'b0, cout, ovf, zero}, {29'b0, snap_c, snap_v, snap_z});
      end
      n0 = n_out;
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("stall_drain_count", n_out - n0, 2);

      // Asynchronous reset with both stages full.
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; rand_op();
      @(posedge clk); #1;
      rand_op();
      @(posedge clk); #2;
      check("prerst_full", {31'b0, out_valid, in_ready}, 32'h2);
      #1 rst = 1'b1;
      in_valid = 1'b0;
      #1;
      check("midrst_out_valid", {31'b0, out_valid}, 32'h0);
      check("midrst_in_ready", {31'b0, in_ready}, 32'h1);
      check_res("midrst", '0);
      @(posedge clk); #1;
      rst = 1'b0;
      a = 32'h1234_5678; b = 32'h0FED_CBA9; sub = 1'b0; cin = 1'b1;
      r = model(a, b, sub, cin);
      in_valid = 1'b1; out_ready = 1'b1;
      #1 check("postrst_in_ready", {31'b0, in_ready}, 32'h1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("postrst_no_stale", {31'b0, out_valid}, 32'h0);
      @(posedge clk); #1;
      check("postrst_valid", {31'b0, out_valid}, 32'h1);
      check_res("postrst", r);

      // Randomized traffic with random back-pressure.
      @(posedge clk); #1;
      in_valid = 1'b0; fire = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!in_valid || fire) begin
            in_valid = ($urandom_range(0, 3) != 0);
            rand_op();
         end
         out_ready = ($urandom_range(0, 3) != 0);
         #1 fire = in_valid && in_ready;
         @(posedge clk); #1;
      end

      in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 10 && q.size() != 0; c++) @(posedge clk);
      #1;
      check("final_drain_empty", q.size(), 0);
      check("final_out_valid", {31'b0, out_valid}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/cla_addsub_pipe32.md
Name: cla_addsub_pipe32

Overview:
- Pipelined 32-bit add/subtract unit built on hierarchical 4-bit carry-lookahead groups.
- Accepts operand pairs over a valid/ready handshake and splits the carry chain across two register stages: low 16 bits in stage 1, high 16 bits in stage 2.
- Returns the sum/difference with carry, signed overflow and zero flags over a second valid/ready handshake.
- Sits between the operand-issue logic and the result writeback in the adder datapath.

Parameters:
- WIDTH, 32, operand width. Fixed at 32; the split point is WIDTH/2. Other values are unsupported.
- GROUP, 4, bits per lookahead group. Fixed at 4.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  unit can accept the operand pair this cycle.
- a  input  32  operand A.
- b  input  32  operand B.
- sub  input  1  0 = A+B, 1 = A-B (B inverted, carry-in 1).
- cin  input  1  carry-in for add. Ignored when sub=1.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- sum  output  32  result.
- cout  output  1  carry out of bit 31. When sub=1, cout=1 means no borrow.
- ovf  output  1  signed overflow: carry into bit 31 XOR carry out of bit 31.
- zero  output  1  sum == 0.

Behaviour:
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Operand preparation: bi = b XOR {32{sub}}; c0 = sub ? 1 : cin. Per bit: p = a XOR bi, g = a AND bi.
- Stage 1 (registered on an input transfer):
  - Bits 15:0 computed with four 4-bit groups plus a second-level lookahead over group P/G.
  - Registers s1_valid, s1_sum_lo[15:0], s1_c16 (carry into bit 16), s1_a_hi[15:0], s1_bi_hi[15:0].
- Stage 2 (registered when stage 2 advances):
  - Bits 31:16 computed from s1_c16 using the same two-level structure.
  - Registers s2_valid, sum, cout, ovf, zero.
  - zero is computed from the full 32-bit result before registering.
- Latency: 2 cycles from input transfer to out_valid when unstalled. Throughput 1 operation per cycle.
- Flow control (no combinational path from out_ready to in_ready is forbidden; it is required):
  - s2_adv = s1_valid && (!s2_valid || out_ready).
  - s1_ready = !s1_valid || s2_adv.
  - in_ready = s1_ready.
- Stall: with out_ready=0 and both stages full, in_ready=0, and all stage registers and outputs hold exactly.
- Simultaneous events:
  - Stage 2 draining while stage 1 advances: the new result replaces the old one in the same cycle; out_valid stays 1.
  - Stage 1 advancing while a new input is accepted: s1_valid stays 1.
- Bubble: s2_valid clears only on an output transfer with no s2_adv.
- Reset (asynchronous assertion, at any time including mid-pipeline):
  - s1_valid=0, s2_valid=0, out_valid=0, sum=0, cout=0, ovf=0, zero=0.
  - All in-flight operations are discarded.
  - in_ready=1 combinationally after reset, since the pipeline is empty.
- Deassertion is assumed synchronised externally; the first accept can occur in the first cycle after deassertion.
- Outputs are registered only; sum and flags do not change while out_valid && !out_ready.
- Data registers may load on advance only; they are not required to clear on a bubble.
- Wrap-around is modulo 2^32: 0xFFFFFFFF+1 gives sum 0, cout 1.

Decomposition:
- Shared package cla_pkg:
  - Constants: WORD_W=32, GROUP_W=4, HALF_W=16.
  - Typedefs: word_t (32-bit) and half_t (16-bit).
  - A pg_t struct {p,g} for group generate/propagate pairs.
- One natural sub-module: cla_block16.
  - Combinational 16-bit two-level lookahead: four 4-bit group units feeding one second-level unit.
  - Inputs: a[15:0], b[15:0], cin. Outputs: s[15:0], c_msb_in (carry into bit 15), cout.
  - Instantiated once per stage.
- The pipeline registers and handshake stay in the top module.

Test Plan:
- Reset, then a=0x0000FFFF, b=0x00000001, sub=0, cin=0 -> two cycles later out_valid=1, sum=0x00010000, cout=0, ovf=0, zero=0. This checks carry propagation across the stage split.
- a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, ovf=1, cout=0. Then a=5, b=5, sub=1 -> sum=0, zero=1, cout=1, ovf=0.
- a=0, b=1, sub=1 -> sum=0xFFFFFFFF, cout=0 (borrow). Then a=0xFFFFFFFF, b=0, cin=1 -> sum=0, cout=1, zero=1.
- Back-to-back stream of 8 operations with out_ready=1 -> in_ready held at 1, 8 results in order on consecutive cycles starting 2 cycles after the first accept.
- Hold out_ready=0 with in_valid=1 continuously -> exactly 2 accepts, then in_ready=0 and outputs stable for 5 cycles. Release out_ready -> results drain in order with no loss or duplication.
- Assert rst mid-stream with both stages full, asynchronously between edges -> out_valid and all flags go to 0 immediately and in_ready=1. The next accepted operation produces a correct result after 2 cycles with no stale results emitted.
